apb_lite_master: RTL and testbench
==================================

Name: apb_lite_master

Overview:
- APB3 initiator for the fabric-side 8-bit register slaves. It is the requester end of the same bus those slaves answer on.
- Converts a single-entry command handshake (write/read, addr, wdata) into one APB transfer: SETUP phase, then ACCESS phase, with PREADY wait-state support, PSLVERR capture and a bounded-wait timeout.
- Returns the result on a response handshake. Used by fabric state machines and self-test logic to drive APB register blocks without the MSS.

Parameters:
- ADDR_WIDTH, 8, width of cmd_addr and PADDR.
- DATA_WIDTH, 8, width of write/read data.
- TIMEOUT_CYCLES, 16, ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; all logic is on the rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- busy  out  1  state != IDLE.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA = 0.
  - rsp_valid, rsp_err, rsp_timeout, rsp_rdata = 0.
  - cmd_ready = 1, busy = 0, wait counter = 0.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On accept, register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, and set PSEL = 1. Next state SETUP.
- SETUP (exactly 1 cycle):
  - PSEL = 1, PENABLE = 0.
  - Next state ACCESS with PENABLE = 1; clear the wait counter.
- ACCESS:
  - PSEL = 1, PENABLE = 1. PADDR, PWDATA and PWRITE are held stable.
  - If PREADY = 1:
    - Capture rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err = PSLVERR, rsp_timeout = 0.
    - Drop PSEL and PENABLE next cycle; go to RESP.
  - Else, if TIMEOUT_CYCLES != 0 and wait counter == TIMEOUT_CYCLES-1:
    - Abort: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
    - Drop PSEL and PENABLE; go to RESP.
  - Else increment the wait counter, which saturates and never wraps.
  - With zero wait states, ACCESS lasts 1 cycle.
- RESP:
  - rsp_valid = 1. rsp_* fields are held stable until rsp_ready.
  - On handshake: rsp_valid = 0 next cycle; go to IDLE.
  - cmd_ready stays 0 (no overlap), so the minimum transfer is 4 PCLK cycles from accept to the next possible accept.
- Latency: accept at edge N gives PSEL at N+1, PENABLE at N+2. With zero wait states, rsp_valid is set at N+3.
- cmd_* inputs are ignored outside IDLE. PRDATA and PSLVERR are sampled only when ACCESS && PREADY.
- Reset mid-transfer: PSEL and PENABLE deassert immediately (asynchronous). No response is generated; the in-flight command is lost.
- Counter width: clog2(TIMEOUT_CYCLES+1), minimum 1.

Decomposition:
- Shared package/header apb_defs: state encoding constants (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3) and the default APB widths, shared with the slave wrappers.
- No sub-module needed. The timeout counter stays inline.

Test Plan:
- Write addr 0x08, data 0xA5, PREADY tied 1 -> PSEL at N+1, PENABLE at N+2 with PADDR = 0x08, PWDATA = 0xA5, PWRITE = 1; rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read addr 0x04, PREADY low for 2 ACCESS cycles, PRDATA = 0x3C on the PREADY cycle -> ACCESS lasts 3 cycles with address held stable; rsp_rdata = 0x3C, rsp_err = 0.
- Read with PSLVERR = 1 on the PREADY cycle -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = captured PRDATA.
- TIMEOUT_CYCLES = 4, PREADY held 0 -> PENABLE high for exactly 4 cycles, then PSEL = 0; rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- Two queued commands, rsp_ready low for 5 cycles -> response held stable, cmd_ready = 0 and PSEL = 0 throughout; the second transfer starts only after the rsp handshake.
- PRESETN pulsed low during ACCESS -> PSEL, PENABLE and rsp_valid = 0 asynchronously; after release, cmd_ready = 1 and busy = 0.

Source files
------------

// File: rtl/apb_lite_master_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths, also used by the slave
// wrappers on the same fabric bus.
package apb_lite_master_pkg;

    localparam int unsigned ApbAddrWidth = 8;
    localparam int unsigned ApbDataWidth = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    // Wait counter must hold 0..timeout; keep at least one bit when the timeout is disabled.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_lite_master.sv
// APB3 initiator: turns one command handshake into a SETUP/ACCESS transfer and returns the
// result (read data, slave error, timeout) on a response handshake.
module apb_lite_master
    import apb_lite_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = ApbAddrWidth,
    parameter int unsigned DATA_WIDTH     = ApbDataWidth,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam int unsigned CntW      = cnt_width(TIMEOUT_CYCLES);
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CntW-1:0] CntLast =
        TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CntW-1:0] CntMax = '1;

    apb_state_e            state_q;
    logic [CntW-1:0]       wait_cnt_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        psel_q   <= 1'b1;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StAccess;
                end
                StAccess: begin
                    if (PREADY) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q     <= PSLVERR;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= StResp;
                    end else if (TimeoutEn && (wait_cnt_q == CntLast)) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        state_q       <= StResp;
                    end else if (wait_cnt_q != CntMax) begin
                        // Saturate so a disabled timeout never wraps back to a match.
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_lite_master.sv
// Directed and randomized transfers against a transaction-level model of the APB initiator.
module tb_apb_lite_master;

    localparam int TMO = 4;

    logic       PCLK;
    logic       PRESETN;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    int n_assert = 0;
    int n_fail   = 0;

    apb_lite_master #(
        .ADDR_WIDTH    (8),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
        int         acc_cycles;
    } exp_t;

    // Outcome of one transfer given how many cycles the slave stalls before PREADY.
    function automatic exp_t model(input bit wr, input logic [7:0] prdata, input bit slverr,
                                   input int nwait);
        exp_t e;
        if (nwait >= TMO) begin
            e.rdata = 8'h00; e.err = 1'b1; e.tmo = 1'b1; e.acc_cycles = TMO;
        end else begin
            e.rdata = wr ? 8'h00 : prdata; e.err = slverr; e.tmo = 1'b0;
            e.acc_cycles = nwait + 1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int nwait, input logic [7:0] prdata, input bit slverr,
                           input int rsp_hold, input bit queued);
        exp_t e;
        int   acc;
        e = model(wr, prdata, slverr, nwait);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_psel", PSEL, 0);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        // Anything on cmd_* from here until IDLE must be ignored.
        cmd_valid = queued;
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        chk("setup_psel", PSEL, 1);
        chk("setup_penable", PENABLE, 0);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwdata", PWDATA, wdata);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_cmd_ready", cmd_ready, 0);
        chk("setup_busy", busy, 1);
        PREADY  = 1'($urandom);
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
        step();
        acc = 0;
        while (PENABLE === 1'b1 && acc < 64) begin
            chk("access_psel", PSEL, 1);
            chk("access_paddr", PADDR, addr);
            chk("access_pwdata", PWDATA, wdata);
            chk("access_pwrite", PWRITE, wr);
            if (acc == nwait) begin
                PREADY = 1'b1; PRDATA = prdata; PSLVERR = slverr;
            end else begin
                PREADY = 1'b0; PRDATA = 8'($urandom); PSLVERR = 1'($urandom);
            end
            acc++;
            step();
        end
        PREADY  = 1'($urandom);
        PRDATA  = 8'($urandom);
        PSLVERR = 1'($urandom);
        chk("access_cycles", acc, e.acc_cycles);
        for (int h = 0; h <= rsp_hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("rsp_psel", PSEL, 0);
            chk("rsp_penable", PENABLE, 0);
            chk("rsp_cmd_ready", cmd_ready, 0);
            rsp_ready = (h == rsp_hold);
            step();
        end
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        PRESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        step();

        // Zero-wait write, two-wait read, slave error read, timeout.
        do_xfer(1'b1, 8'h08, 8'hA5, 0, 8'h77, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 8'h04, 8'h11, 2, 8'h3C, 1'b0, 0, 1'b0);
        do_xfer(1'b0, 8'h10, 8'h00, 1, 8'h5A, 1'b1, 1, 1'b0);
        do_xfer(1'b0, 8'h20, 8'h00, 10, 8'hFF, 1'b0, 0, 1'b0);
        // Back-to-back with a stalled response: the second starts only after the handshake.
        do_xfer(1'b1, 8'h31, 8'hC3, 0, 8'h00, 1'b0, 5, 1'b1);
        do_xfer(1'b0, 8'h32, 8'h00, 0, 8'h96, 1'b0, 0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            do_xfer(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)),
                    8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    (i != 15) ? 1'($urandom) : 1'b0);
        end
        cmd_valid = 1'b0;

        // Reset in the middle of ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h44; cmd_wdata = 8'h00;
        step();
        cmd_valid = 1'b0;
        PREADY = 1'b0;
        step();
        step();
        chk("mid_penable", PENABLE, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("arst_psel", PSEL, 0);
        chk("arst_penable", PENABLE, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        #2 PRESETN = 1'b1;
        step();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_psel", PSEL, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        do_xfer(1'b0, 8'h55, 8'h00, 1, 8'hE7, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
